// File: rtl/prog_timer.sv
// prog_timer: programmable tick timer with prescaler, one-shot and periodic modes.
//
// Ports:
//   clk        - single clock, all logic on the rising edge
//   rst        - synchronous active-high reset
//   start      - pulse: begin counting, or restart if already running
//   stop       - pulse: abort counting and return to idle
//   pause      - level: while high in RUN, prescaler and counter hold
//   mode       - 0 = one-shot, 1 = periodic; sampled at start and at each wrap
//   period_wr  - write strobe for period_in (a zero value is ignored)
//   period_in  - new period, in ticks
//   timeout    - registered one-cycle pulse at period expiry
//   busy       - high in RUN, including while paused
//   count      - current tick count, 0..active_period-1
//   period     - shadow period register
//
// Control is pulse/level based with no handshake: start, stop and period_wr
// act on the edge where they are sampled high. Per-edge priority is
// rst > stop > start > pause > tick.
module prog_timer #(
  parameter int              CNT_WIDTH      = 32,
  parameter int              PRESCALE       = 1,
  parameter longint unsigned DEFAULT_PERIOD = 100_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic                 mode,
  input  logic                 period_wr,
  input  logic [CNT_WIDTH-1:0] period_in,
  output logic                 timeout,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] period
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]        PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [CNT_WIDTH-1:0] DEF_P     = CNT_WIDTH'(DEFAULT_PERIOD);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [PW-1:0]        presc_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] shadow_q;
  logic [CNT_WIDTH-1:0] act_period_q;
  logic                 act_mode_q;

  logic wr_valid;
  logic tick;
  logic terminal;

  assign wr_valid = period_wr && (period_in != '0);
  assign tick     = (state_q == RUN) && !pause && (presc_q == PRESC_MAX);
  assign terminal = tick && (count_q == act_period_q - CNT_WIDTH'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (stop)
      state_d = IDLE;
    else if (start)
      state_d = RUN;
    else if ((state_q == RUN) && terminal && !act_mode_q)
      state_d = IDLE;
  end

  // Output logic
  always_comb begin
    busy   = (state_q == RUN);
    count  = count_q;
    period = shadow_q;
  end

  // Datapath: prescaler, counter, shadow/active period, timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      count_q      <= '0;
      shadow_q     <= DEF_P;
      act_period_q <= DEF_P;
      act_mode_q   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (wr_valid)
        shadow_q <= period_in;

      if (stop) begin
        presc_q <= '0;
        count_q <= '0;
      end else if (start) begin
        presc_q      <= '0;
        count_q      <= '0;
        // A write in the start cycle goes straight through to the new run.
        act_period_q <= wr_valid ? period_in : shadow_q;
        act_mode_q   <= mode;
      end else if ((state_q == RUN) && !pause) begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          if (terminal) begin
            count_q <= '0;
            timeout <= 1'b1;
            if (act_mode_q) begin
              // Periodic wrap picks up whatever the shadow/mode hold now.
              act_period_q <= shadow_q;
              act_mode_q   <= mode;
            end
          end else begin
            count_q <= count_q + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_timer.sv
module tb_prog_timer;

  localparam int W = 32;
  localparam logic [W-1:0] DEF_P = 32'd1000;

  logic         clk = 1'b0;
  logic         rst;
  // PRESCALE = 1 instance
  logic         start, stop, pause, mode, period_wr;
  logic [W-1:0] period_in;
  logic         timeout, busy;
  logic [W-1:0] count, period;
  // PRESCALE = 3 instance
  logic         start3, stop3, pause3, mode3, period_wr3;
  logic [W-1:0] period_in3;
  logic         timeout3, busy3;
  logic [W-1:0] count3, period3;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_per;

  prog_timer #(.CNT_WIDTH(W), .PRESCALE(1), .DEFAULT_PERIOD(1000)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .period_wr(period_wr), .period_in(period_in),
    .timeout(timeout), .busy(busy), .count(count), .period(period)
  );

  prog_timer #(.CNT_WIDTH(W), .PRESCALE(3), .DEFAULT_PERIOD(1000)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .stop(stop3), .pause(pause3),
    .mode(mode3), .period_wr(period_wr3), .period_in(period_in3),
    .timeout(timeout3), .busy(busy3), .count(count3), .period(period3)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  // Driver / scoreboard tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask

  // Queue expectations for the coming edge, clock it, then compare.
  task automatic cyc(input string tag, input logic b, input logic t, input logic [W-1:0] c);
    push(W'(b));
    push(W'(t));
    push(c);
    push(exp_per);
    step();
    chk({tag, ".busy"},    W'(busy));
    chk({tag, ".timeout"}, W'(timeout));
    chk({tag, ".count"},   count);
    chk({tag, ".period"},  period);
  endtask

  initial begin
    logic [W-1:0] c;
    logic         b, t;

    rst = 1'b1;
    start = 0; stop = 0; pause = 0; mode = 0; period_wr = 0; period_in = '0;
    start3 = 0; stop3 = 0; pause3 = 0; mode3 = 0; period_wr3 = 0; period_in3 = '0;
    exp_per = DEF_P;
    step();

    // Reset state
    cyc("reset", 0, 0, 0);
    push(W'(0)); push(W'(0)); push(DEF_P);
    chk("reset3.busy", W'(busy3));
    chk("reset3.timeout", W'(timeout3));
    chk("reset3.period", period3);
    rst = 1'b0;

    // Zero write ignored
    period_wr = 1; period_in = '0;
    cyc("zero_write", 0, 0, 0);

    // One-shot, period 4
    period_in = 32'd4; exp_per = 32'd4;
    cyc("wr4", 0, 0, 0);
    period_wr = 0; mode = 0;
    start = 1;
    cyc("os_start", 1, 0, 0);
    start = 0;
    for (int e = 1; e <= 3; e++) cyc("os_cnt", 1, 0, W'(e));
    cyc("os_expire", 0, 1, 0);
    cyc("os_idle", 0, 0, 0);

    // Pause: period 10, pause 7 cycles at count 3
    period_wr = 1; period_in = 32'd10; exp_per = 32'd10;
    cyc("wr10", 0, 0, 0);
    period_wr = 0;
    start = 1;
    cyc("pz_start", 1, 0, 0);
    start = 0;
    for (int e = 1; e <= 17; e++) begin
      pause = (e >= 4 && e <= 10);
      b = 1; t = 0;
      if (e <= 3)       c = W'(e);
      else if (e <= 10) c = W'(3);
      else if (e <= 16) c = W'(e - 7);
      else begin c = '0; b = 0; t = 1; end
      cyc("pz_run", b, t, c);
    end
    pause = 0;

    // Stop on terminal tick (periodic, period 4)
    period_wr = 1; period_in = 32'd4; exp_per = 32'd4;
    cyc("wr4b", 0, 0, 0);
    period_wr = 0; mode = 1;
    start = 1;
    cyc("st_start", 1, 0, 0);
    start = 0;
    for (int e = 1; e <= 3; e++) cyc("st_cnt", 1, 0, W'(e));
    stop = 1;
    cyc("stop_on_term", 0, 0, 0);
    stop = 0;
    cyc("stop_after", 0, 0, 0);

    // Restart on terminal tick
    start = 1;
    cyc("rs_start", 1, 0, 0);
    start = 0;
    for (int e = 1; e <= 3; e++) cyc("rs_cnt", 1, 0, W'(e));
    start = 1;
    cyc("restart_on_term", 1, 0, 0);
    start = 0;
    for (int e = 1; e <= 3; e++) cyc("rs_cnt2", 1, 0, W'(e));
    cyc("rs_pulse", 1, 1, 0);
    cyc("rs_wrap", 1, 0, 1);
    stop = 1;
    cyc("rs_stop", 0, 0, 0);
    stop = 0;

    // start + period_wr same cycle: write-through
    mode = 0; start = 1; period_wr = 1; period_in = 32'd3; exp_per = 32'd3;
    cyc("wt_start", 1, 0, 0);
    start = 0; period_wr = 0;
    cyc("wt_c1", 1, 0, 1);
    cyc("wt_c2", 1, 0, 2);
    cyc("wt_expire", 0, 1, 0);

    // start in IDLE with pause high
    pause = 1; start = 1;
    cyc("ps_start", 1, 0, 0);
    start = 0;
    for (int e = 0; e < 3; e++) cyc("ps_hold", 1, 0, 0);
    pause = 0;
    cyc("ps_go", 1, 0, 1);
    stop = 1;
    cyc("ps_stop", 0, 0, 0);
    stop = 0;

    // Reset mid-run at count 5, with start/period_wr in the reset cycle
    mode = 1; start = 1; period_wr = 1; period_in = 32'd10; exp_per = 32'd10;
    cyc("rm_start", 1, 0, 0);
    start = 0; period_wr = 0;
    for (int e = 1; e <= 5; e++) cyc("rm_cnt", 1, 0, W'(e));
    rst = 1; start = 1; period_wr = 1; period_in = 32'd7; exp_per = DEF_P;
    cyc("rst_mid", 0, 0, 0);
    rst = 0; start = 0; period_wr = 0;
    cyc("post_rst", 0, 0, 0);
    cyc("post_rst2", 0, 0, 0);

    // PRESCALE = 3, periodic period 2, later changed to 5
    period_wr3 = 1; period_in3 = 32'd2;
    step();
    period_wr3 = 0; mode3 = 1; start3 = 1;
    step();
    start3 = 0;
    for (int e = 1; e <= 66; e++) begin
      if (e == 31) begin period_wr3 = 1; period_in3 = 32'd5; end
      else period_wr3 = 0;
      t = (e == 6 || e == 12 || e == 18 || e == 24 || e == 30 ||
           e == 36 || e == 51 || e == 66);
      push(W'(t));
      push(W'(1));
      step();
      chk("ps3.timeout", W'(timeout3));
      chk("ps3.busy", W'(busy3));
    end
    push(32'd5);
    chk("ps3.period", period3);
    stop3 = 1;
    push(W'(0));
    step();
    chk("ps3.stop_busy", W'(busy3));
    stop3 = 0;

    // Final report
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expected values never compared", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
